mem_ctrl: RTL
=============

Name: mem_ctrl

Overview:
- Sits directly downstream of the load/store buffer and the instruction-fetch unit.
- Arbitrates their word/half/byte requests onto the single byte-wide synchronous RAM/IO port.
- Serialises multi-byte accesses little-endian and returns one assembled 32-bit result with a one-cycle done pulse.
- Handles speculative-fetch abort on rollback and stalls IO writes while the UART buffer is full.

Parameters:
ADDR_W, 32, address width of all request and RAM addresses
IO_SEL, 2'b11, value of addr[17:16] that marks an IO (UART) address

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
rdy  in  1  global enable; low freezes all state
rollback  in  1  branch mispredict; aborts an in-flight instruction fetch
if_en  in  1  fetch request (level, held until if_done)
if_pc  in  ADDR_W  fetch address (4-byte word)
if_done  out  1  one-cycle pulse, if_data valid
if_data  out  32  fetched instruction
lsb_en  in  1  LSB request (level, held until lsb_done)
lsb_wr  in  1  0 load, 1 store
lsb_a  in  ADDR_W  byte address
lsb_l  in  3  length in bytes: 1, 2 or 4
lsb_w  in  32  store data, little-endian
lsb_done  out  1  one-cycle pulse, access complete
lsb_r  out  32  load data, zero-extended (LSB sign-extends)
ram_din  in  8  RAM/IO read byte, valid one cycle after ram_a
ram_dout  out  8  write byte
ram_a  out  ADDR_W  byte address
ram_wr  out  1  1 write, 0 read
io_buffer_full  in  1  UART buffer full

Behaviour:
- Reset: state IDLE, byte counter 0, all outputs 0 (ram_wr=0, ram_a=0, if_done=lsb_done=0, data outputs 0).
- rdy=0: no state change; ram_wr driven 0; done outputs hold 0.
- States: IDLE, IF (4-byte read), LOAD, STORE. Counter cnt is 3 bits; len register holds the length.
- IDLE: if lsb_en, go to LOAD/STORE per lsb_wr; this takes priority over if_en. Otherwise, if if_en and not rollback, go to IF. Latch address and length (4 for IF), cnt=0.
- Read states: cycle k (k=0..len-1) drives ram_a=base+k, ram_wr=0. The byte from cycle k is captured in cycle k+1 into bits [8k+7:8k]. After len bytes are captured, pulse done with data, then return to IDLE.
- Read latency: the done pulse occurs len+1 cycles after the accept edge.
- STORE: cycle k drives ram_a=base+k, ram_dout=lsb_w[8k+7:8k], ram_wr=1. lsb_done pulses the cycle after the last byte is written.
- IO store stall: if base[17:16]==IO_SEL and io_buffer_full=1, drive ram_wr=0 and do not advance cnt. Resume when io_buffer_full deasserts. IO loads are not stalled.
- Done pulses: exactly one cycle. The next request is sampled no earlier than the cycle after done, so a requester that drops en on the done edge is never re-served.
- Rollback during IF: abort immediately, go to IDLE, no if_done. Rollback in the same cycle as an IF done: suppress if_done.
- Rollback during LOAD/STORE: ignored; the access completes normally (LSB relies on this).
- Unused upper bytes of lsb_r are 0. Address increment wraps modulo 2^ADDR_W.
- Reset mid-access: abort immediately; no done pulse.

Decomposition:
- Shared def package: ADDR_W, IO_SEL, and state encodings MC_IDLE/MC_IF/MC_LOAD/MC_STORE.
- One natural sub-module, mem_byte_shift: the byte assembler/disassembler (cnt, len → byte lane select and result accumulate).
- Arbiter and FSM stay in mem_ctrl.

Test Plan:
- Fetch: if_pc=0x100, RAM[0x100..0x103]=13,05,A0,00. Expect if_data=0x00A00513, if_done exactly 5 cycles after accept, ram_wr never 1.
- Load half: lsb_wr=0, lsb_a=0x2002, lsb_l=2, RAM=34,12. Expect lsb_r=0x00001234, one done pulse 3 cycles after accept.
- Store word: lsb_w=0xDEADBEEF, lsb_a=0x3000, lsb_l=4. Expect writes EF,BE,AD,DE at 0x3000..0x3003 on 4 consecutive cycles, then lsb_done.
- Arbitration: if_en and lsb_en rise in the same cycle. Expect LSB served first; the fetch starts the cycle after lsb_done.
- IO stall: byte store to 0x30000, io_buffer_full high for 3 cycles. Expect ram_wr=0 for those cycles, a single write of the byte after release, then done.
- Rollback on the 2nd cycle of a fetch. Expect return to IDLE, no if_done, and a new lsb_en accepted the next cycle; rollback during a store does not alter its 4 writes.

Source files
------------

// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the memory controller: widths, IO decode, FSM states.
// Latency: n/a (package).
// Backpressure: n/a (package).
package mem_ctrl_pkg;

  localparam int         ADDR_W = 32;
  // addr[17:16] value that selects the UART window
  localparam logic [1:0] IO_SEL = 2'b11;

  typedef enum logic [1:0] {
    MC_IDLE  = 2'd0,
    MC_IF    = 2'd1,
    MC_LOAD  = 2'd2,
    MC_STORE = 2'd3
  } mc_state_e;

endpackage

// File: rtl/mem_ctrl_if.sv
// Bundle between the requesters (fetch, LSB), the byte RAM/IO port and mem_ctrl.
// Latency: n/a (wiring only).
// Backpressure: rdy freezes the controller; io_buffer_full stalls IO stores.
// Ports: master = requesters + RAM model side, slave = mem_ctrl side.
interface mem_ctrl_if;
  import mem_ctrl_pkg::*;

  logic              rdy;
  logic              rollback;
  // instruction fetch
  logic              if_en;
  logic [ADDR_W-1:0] if_pc;
  logic              if_done;
  logic [31:0]       if_data;
  // load/store buffer
  logic              lsb_en;
  logic              lsb_wr;
  logic [ADDR_W-1:0] lsb_a;
  logic [2:0]        lsb_l;
  logic [31:0]       lsb_w;
  logic              lsb_done;
  logic [31:0]       lsb_r;
  // byte-wide RAM/IO port
  logic [7:0]        ram_din;
  logic [7:0]        ram_dout;
  logic [ADDR_W-1:0] ram_a;
  logic              ram_wr;
  logic              io_buffer_full;

  modport master (
    output rdy, rollback, if_en, if_pc, lsb_en, lsb_wr, lsb_a, lsb_l, lsb_w,
           ram_din, io_buffer_full,
    input  if_done, if_data, lsb_done, lsb_r, ram_dout, ram_a, ram_wr
  );

  modport slave (
    input  rdy, rollback, if_en, if_pc, lsb_en, lsb_wr, lsb_a, lsb_l, lsb_w,
           ram_din, io_buffer_full,
    output if_done, if_data, lsb_done, lsb_r, ram_dout, ram_a, ram_wr
  );

endinterface

// File: rtl/mem_byte_shift.sv
// Byte lane steering: picks the store byte for the current cycle and merges the read byte.
// Latency: purely combinational.
// Backpressure: none; the caller decides when cnt advances.
// Ports: i_cnt/i_len position in the burst, i_wdat store word, i_acc/i_din read accumulate,
//        o_wbyte store byte, o_acc_nxt merged word, o_last_rd/o_last_wr end-of-burst flags.
module mem_byte_shift (
  input  logic [2:0]  i_cnt,
  input  logic [2:0]  i_len,
  input  logic [31:0] i_wdat,
  input  logic [31:0] i_acc,
  input  logic [7:0]  i_din,
  output logic [7:0]  o_wbyte,
  output logic [31:0] o_acc_nxt,
  output logic        o_last_rd,
  output logic        o_last_wr
);

  logic [1:0] w_lane;
  logic       w_cap;

  // ram_din in cycle k carries the byte addressed in cycle k-1
  assign w_lane = 2'(i_cnt - 3'd1);
  assign w_cap  = (i_cnt != 3'd0) && (i_cnt <= i_len);

  always_comb begin
    o_wbyte = 8'h00;
    if (!i_cnt[2]) o_wbyte = i_wdat[8*i_cnt[1:0] +: 8];
    o_acc_nxt = i_acc;
    if (w_cap) o_acc_nxt[8*w_lane +: 8] = i_din;
  end

  // reads finish once the last byte has been captured, stores once it is driven
  assign o_last_rd = (i_cnt >= i_len);
  assign o_last_wr = (({1'b0, i_cnt} + 4'd1) >= {1'b0, i_len});

endmodule

// File: rtl/mem_ctrl.sv
// Arbitrates fetch and LSB requests onto one byte-wide RAM/IO port, little-endian.
// Latency: read done pulse len+1 cycles after accept; store done len cycles after accept.
// Backpressure: rdy=0 freezes everything; IO stores hold while io_buffer_full is high.
// Ports: clk, rst (sync, active-high), bus (mem_ctrl_if.slave: requests, results, RAM port).
module mem_ctrl
  import mem_ctrl_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  mem_ctrl_if.slave bus
);

  mc_state_e         r_state;
  logic [2:0]        r_cnt;
  logic [2:0]        r_len;
  logic [ADDR_W-1:0] r_base;
  logic [31:0]       r_wdat;
  logic [31:0]       r_acc;
  logic [31:0]       r_if_data;
  logic [31:0]       r_lsb_r;
  logic              r_if_done;
  logic              r_lsb_done;

  logic [7:0]        w_wbyte;
  logic [31:0]       w_acc_nxt;
  logic              w_last_rd;
  logic              w_last_wr;
  logic              w_stall;

  mem_byte_shift u_shift (
    .i_cnt     (r_cnt),
    .i_len     (r_len),
    .i_wdat    (r_wdat),
    .i_acc     (r_acc),
    .i_din     (bus.ram_din),
    .o_wbyte   (w_wbyte),
    .o_acc_nxt (w_acc_nxt),
    .o_last_rd (w_last_rd),
    .o_last_wr (w_last_wr)
  );

  assign w_stall = (r_base[17:16] == IO_SEL) && bus.io_buffer_full;

  // address wraps naturally in ADDR_W bits
  assign bus.ram_a    = r_base + ADDR_W'(r_cnt);
  assign bus.ram_dout = w_wbyte;
  assign bus.ram_wr   = bus.rdy && (r_state == MC_STORE) && !w_stall;
  // a rollback coinciding with the fetch done cycle kills the result
  assign bus.if_done  = r_if_done && bus.rdy && !bus.rollback;
  assign bus.lsb_done = r_lsb_done && bus.rdy;
  assign bus.if_data  = r_if_data;
  assign bus.lsb_r    = r_lsb_r;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= MC_IDLE;
      r_cnt      <= 3'd0;
      r_len      <= 3'd0;
      r_base     <= '0;
      r_wdat     <= 32'h0;
      r_acc      <= 32'h0;
      r_if_data  <= 32'h0;
      r_lsb_r    <= 32'h0;
      r_if_done  <= 1'b0;
      r_lsb_done <= 1'b0;
    end else if (bus.rdy) begin
      r_if_done  <= 1'b0;
      r_lsb_done <= 1'b0;
      case (r_state)
        MC_IDLE: begin
          // requests are not sampled during a done cycle, so a requester that
          // drops en on the done edge is never served twice
          if (!r_if_done && !r_lsb_done) begin
            r_cnt <= 3'd0;
            r_acc <= 32'h0;
            if (bus.lsb_en) begin
              r_state <= bus.lsb_wr ? MC_STORE : MC_LOAD;
              r_base  <= bus.lsb_a;
              r_len   <= bus.lsb_l;
              r_wdat  <= bus.lsb_w;
            end else if (bus.if_en && !bus.rollback) begin
              r_state <= MC_IF;
              r_base  <= bus.if_pc;
              r_len   <= 3'd4;
            end
          end
        end
        MC_IF, MC_LOAD: begin
          r_acc <= w_acc_nxt;
          if ((r_state == MC_IF) && bus.rollback) begin
            r_state <= MC_IDLE;
            r_cnt   <= 3'd0;
          end else if (w_last_rd) begin
            r_state <= MC_IDLE;
            r_cnt   <= 3'd0;
            if (r_state == MC_IF) begin
              r_if_done <= 1'b1;
              r_if_data <= w_acc_nxt;
            end else begin
              r_lsb_done <= 1'b1;
              r_lsb_r    <= w_acc_nxt;
            end
          end else begin
            r_cnt <= r_cnt + 3'd1;
          end
        end
        MC_STORE: begin
          if (!w_stall) begin
            if (w_last_wr) begin
              r_state    <= MC_IDLE;
              r_cnt      <= 3'd0;
              r_lsb_done <= 1'b1;
            end else begin
              r_cnt <= r_cnt + 3'd1;
            end
          end
        end
        default: r_state <= MC_IDLE;
      endcase
    end
  end

endmodule
